// File: rtl/internram_requester.sv
// internram_requester: turns CPU/DMA byte/half/word accesses into word-addressed internal RAM cycles.
// Define INTERNRAM_RMW_EN for RAM macros without byte enables (sub-word writes become read-modify-write).
module internram_requester #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ack,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_busy,
    output logic [ADDR_WIDTH-3:0] ram_address,
    output logic                  ram_wren,
    output logic [31:0]           ram_data,
    output logic [3:0]            ram_byteena,
    input  logic [31:0]           ram_q
);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR
`ifdef INTERNRAM_RMW_EN
        , RMW_RD,
        RMW_DATA
`endif
    } state_t;

    state_t                state, next_state;
    logic [1:0]            lat_size, next_size;
    logic [1:0]            lat_a, next_a;
    logic                  next_ack, next_wren;
    logic [31:0]           next_rdata, next_data;
    logic [3:0]            next_byteena;
    logic [ADDR_WIDTH-3:0] next_address;

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: lane_enables = 4'b0001 << a;
            SZ_HALF: lane_enables = a[1] ? 4'b1100 : 4'b0011;
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: replicate = {4{d[7:0]}};
            SZ_HALF: replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    // ARM7 misaligned-load rules: byte/half zero-extended, halves and words rotated.
    function automatic logic [31:0] format_read(input logic [1:0] size, input logic [1:0] a,
                                                input logic [31:0] q);
        logic [31:0] byte_sh;
        logic [31:0] half_z;
        logic [63:0] rot;
        byte_sh = q >> {a, 3'b000};
        half_z  = {16'h0000, a[1] ? q[31:16] : q[15:0]};
        rot     = {q, q} >> {a, 3'b000};
        case (size)
            SZ_BYTE: format_read = {24'h000000, byte_sh[7:0]};
            SZ_HALF: format_read = a[0] ? {half_z[7:0], half_z[31:8]} : half_z;
            default: format_read = rot[31:0];
        endcase
    endfunction

`ifdef INTERNRAM_RMW_EN
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] new_word,
                                                input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            merge_lanes[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    endfunction
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        next_state   = state;
        next_size    = lat_size;
        next_a       = lat_a;
        next_ack     = 1'b0;
        next_rdata   = cpu_rdata;
        next_address = ram_address;
        next_wren    = 1'b0;
        next_data    = ram_data;
        next_byteena = 4'b0000;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    next_size    = cpu_size;
                    next_a       = cpu_addr[1:0];
                    next_address = cpu_addr[ADDR_WIDTH-1:2];
                    if (cpu_we) begin
                        next_data = replicate(cpu_size, cpu_wdata);
`ifdef INTERNRAM_RMW_EN
                        if (cpu_size == SZ_BYTE || cpu_size == SZ_HALF) begin
                            next_state = RMW_RD;
                        end else begin
                            next_state   = WR;
                            next_wren    = 1'b1;
                            next_byteena = 4'b1111;
                        end
`else
                        next_state   = WR;
                        next_wren    = 1'b1;
                        next_byteena = lane_enables(cpu_size, cpu_addr[1:0]);
`endif
                    end else begin
                        next_state = RD_ADDR;
                    end
                end
            end
            RD_ADDR: next_state = RD_DATA;
            RD_DATA: begin
                next_state = IDLE;
                next_rdata = format_read(lat_size, lat_a, ram_q);
                next_ack   = 1'b1;
            end
            WR: begin
                next_state = IDLE;
                next_ack   = 1'b1;
            end
`ifdef INTERNRAM_RMW_EN
            RMW_RD: next_state = RMW_DATA;
            RMW_DATA: begin
                next_state   = WR;
                next_wren    = 1'b1;
                next_byteena = 4'b1111;
                next_data    = merge_lanes(ram_q, ram_data, lane_enables(lat_size, lat_a));
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_size    <= 2'd0;
            lat_a       <= 2'd0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 32'h0;
            cpu_busy    <= 1'b0;
            ram_address <= '0;
            ram_wren    <= 1'b0;
            ram_data    <= 32'h0;
            ram_byteena <= 4'b0000;
        end else begin
            state       <= next_state;
            lat_size    <= next_size;
            lat_a       <= next_a;
            cpu_ack     <= next_ack;
            cpu_rdata   <= next_rdata;
            cpu_busy    <= (next_state != IDLE);
            ram_address <= next_address;
            ram_wren    <= next_wren;
            ram_data    <= next_data;
            ram_byteena <= next_byteena;
        end
    end

endmodule

// File: doc/internram_requester.md
# internram_requester

Bus-side initiator for the 32-bit internal work RAM (16384 words). Accepts CPU/DMA byte, halfword and word accesses on a level-request/pulse-acknowledge interface. Converts them into word-addressed RAM cycles with byte-lane enables and replicated write data. Rotates and zero-extends read data per ARM7 misaligned-load rules. Sits between the GBA memory arbiter and the internal RAM macro.

## Interface
- ADDR_WIDTH, 16: byte-address width; RAM word address is ADDR_WIDTH-2 bits.
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; returns block to IDLE immediately.
- cpu_req  in  1  access request; level, sampled every rising edge.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_size  in  2  0 byte, 1 halfword, 2 word, 3 treated as word.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  formatted read data; valid while cpu_ack=1, held until next read completes.
- cpu_busy  out  1  high from acceptance until the cycle before cpu_ack.
- ram_address  out  ADDR_WIDTH-2  word address = cpu_addr[ADDR_WIDTH-1:2].
- ram_wren  out  1  write strobe, one cycle per write.
- ram_data  out  32  write data, lane-replicated.
- ram_byteena  out  4  byte-lane enables; 0 outside write cycles.
- ram_q  in  32  RAM read data, valid in the cycle after ram_address is presented.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, and RMW_RD / RMW_DATA (macro only). cpu_busy = (state != IDLE).
- Acceptance: rising edge with cpu_req=1 and state IDLE latches we/size/addr/wdata. Requests during busy are ignored, not queued.
- Read: IDLE -> RD_ADDR (ram_address driven) -> RD_DATA (ram_q valid). At the edge leaving RD_DATA, load cpu_rdata, pulse cpu_ack, return to IDLE.
- Read formatting (a = addr[1:0]):
  - Byte: zero-extended lane a.
  - Half: lane pair addr[1], zero-extended, then rotated right 8 if addr[0]=1.
  - Word: ram_q rotated right 8*a.
- Write (non-RMW): IDLE -> WR. In WR: ram_wren=1, ram_byteena set, ram_data set. At the edge leaving WR, pulse cpu_ack and return to IDLE.
- Byte enables and data:
  - Byte: byteena = 1<<a; data = {4{wdata[7:0]}}.
  - Half: byteena = addr[1] ? 1100 : 0011; data = {2{wdata[15:0]}}; addr[0] ignored.
  - Word: byteena = 1111; data = wdata; a ignored.
- All RAM-side and cpu-side outputs are registered.
- Back-to-back: cpu_ack cycle is an IDLE cycle, so cpu_req held in it is accepted at the edge ending it. The requester must drop or change cpu_req in the ack cycle.
- Reset mid-operation: the access is aborted, no ack is issued, and ram_wren drops asynchronously. A write in progress may be lost.

## Timing
- Reset values: cpu_ack 0, cpu_rdata 0, cpu_busy 0, ram_address 0, ram_wren 0, ram_data 0, ram_byteena 0, state IDLE.
- Request accepted at edge N:
  - Read: cpu_ack high in cycle N+3.
  - Write: ram_wren high in cycle N+1; cpu_ack high in cycle N+2.
  - RMW write (macro on): read in N+1, ram_q in N+2, merged full-word write in N+3; cpu_ack high in N+4.
- Sustained throughput: one read per 3 cycles, one write per 2 cycles.
- ram_wren is never high for more than one consecutive cycle per access.

## Configuration
- INTERNRAM_RMW_EN defined: for RAM macros without byte enables.
  - Byte and half writes go WR via RMW_RD -> RMW_DATA -> WR.
  - ram_q lanes are merged with new data and written with ram_byteena=1111.
  - Word writes skip the RMW states.
- Undefined: all writes are single-cycle with lane enables as above; RMW states do not exist.

## Test plan
- Reset mid-write: assert reset during WR -> ram_wren=0 immediately, no cpu_ack, all outputs 0; first request after release behaves normally.
- Word write 0xDEADBEEF to 0x0104, then word read 0x0104 -> ram_address=0x041, byteena=1111 in N+1, ack in N+2; read ack in N+3 with rdata=0xDEADBEEF.
- Byte write 0xAB to 0x0106 -> byteena=0100, ram_data=0xABABABAB. Byte read 0x0106 with ram_q=0x11AB2233 -> rdata=0x000000AB.
- Half read 0x0103 with ram_q=0xAABBCCDD -> rdata=0xBB0000AA. Word read 0x0101 with the same ram_q -> rdata=0xDDAABBCC.
- Back-to-back: cpu_req held high with alternating write/read -> accepted in each ack cycle; requests raised while cpu_busy=1 produce no RAM activity.
- With INTERNRAM_RMW_EN: half write 0x1234 to 0x0002 over ram_q=0xAAAABBBB -> single write 0x1234BBBB, byteena=1111, ack in N+4.
